// File: rtl/icache_sa.sv
// ---------------------------------------------------------------------------
// icache_sa
//   Set-associative, read-only instruction cache between the CPU fetch port
//   and instruction memory. It has configurable sets, associativity (1 or 2
//   ways) and block size. It uses LRU replacement and supports a whole-cache
//   flush. The cache never writes instruction memory.
//
//   Optional feature macro: ICACHE_STATS_EN
//     When defined, adds saturating hit_count / miss_count outputs.
//
// Ports
//   CLK             in   1                   clock, all state on rising edge
//   RESET_N         in   1                   asynchronous active-low reset
//   I_READ          in   1                   fetch request valid
//   I_ADDRESS       in   ADDR_W              fetch byte address
//   I_FLUSH         in   1                   invalidate all lines (pulse)
//   I_READDATA      out  WORD_W              fetched word (0 when no hit)
//   I_BUSYWAIT      out  1                   CPU stall
//   i_mem_read      out  1                   block read request
//   i_mem_address   out  ADDR_W-OFF_W        block address {tag,index}
//   i_mem_readdata  in   BLOCK_WORDS*WORD_W  returned block, word 0 in LSBs
//   i_mem_busywait  in   1                   memory busy; data valid as it falls
//   hit_count       out  32                  (ICACHE_STATS_EN) IDLE hit cycles
//   miss_count      out  32                  (ICACHE_STATS_EN) misses started
// ---------------------------------------------------------------------------
module icache_sa #(
    parameter int ADDR_W      = 10,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 8,
    parameter int WAYS        = 2
) (
    input  logic                                            CLK,
    input  logic                                            RESET_N,
    input  logic                                            I_READ,
    input  logic [ADDR_W-1:0]                               I_ADDRESS,
    input  logic                                            I_FLUSH,
    output logic [WORD_W-1:0]                               I_READDATA,
    output logic                                            I_BUSYWAIT,
    output logic                                            i_mem_read,
    output logic [ADDR_W-$clog2(BLOCK_WORDS*WORD_W/8)-1:0]  i_mem_address,
    input  logic [BLOCK_WORDS*WORD_W-1:0]                   i_mem_readdata,
    input  logic                                            i_mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                                     hit_count,
    output logic [31:0]                                     miss_count
`endif
);

    localparam int BYTE_OFF_W = $clog2(WORD_W / 8);
    localparam int WORD_OFF_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W      = BYTE_OFF_W + WORD_OFF_W;
    localparam int IDX_W      = $clog2(SETS);
    localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
    localparam int BADDR_W    = TAG_W + IDX_W;
    localparam int BLK_W      = BLOCK_WORDS * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    // Storage: valid bits are reset, tag/data arrays are not.
    logic [SETS-1:0]    valid_r [WAYS];
    logic [TAG_W-1:0]   tag_r   [WAYS][SETS];
    logic [BLK_W-1:0]   data_r  [WAYS][SETS];
    // Per set: the way to evict next once both ways are valid.
    logic [SETS-1:0]    lru_r;

    state_t             state_r;
    state_t             state_s;
    logic [BADDR_W-1:0] miss_addr_r;
    logic               victim_r;
    logic               victim_s;
    logic               flush_pend_r;
    logic [BLK_W-1:0]   fill_data_r;

    logic [IDX_W-1:0]      index_s;
    logic [TAG_W-1:0]      tag_s;
    logic [WORD_OFF_W-1:0] word_s;
    logic [IDX_W-1:0]      fill_index_s;
    logic [TAG_W-1:0]      fill_tag_s;
    logic [1:0]            way_hit_s;
    logic [1:0]            set_valid_s;
    logic                  hit_s;
    logic                  hit_way_s;
    logic [BLK_W-1:0]      hit_block_s;
    logic [WORD_W-1:0]     word_data_s;
    logic                  addr_unused_s;

    assign index_s       = I_ADDRESS[OFF_W +: IDX_W];
    assign tag_s         = I_ADDRESS[ADDR_W-1 -: TAG_W];
    assign word_s        = I_ADDRESS[BYTE_OFF_W +: WORD_OFF_W];
    assign fill_index_s  = miss_addr_r[IDX_W-1:0];
    assign fill_tag_s    = miss_addr_r[BADDR_W-1 -: TAG_W];
    // Byte-within-word address bits carry no meaning for word fetches.
    assign addr_unused_s = ^I_ADDRESS[BYTE_OFF_W-1:0];

    // Tag lookup in every way of the addressed set and hit-block selection.
    always_comb begin
        way_hit_s   = 2'b00;
        set_valid_s = 2'b00;
        hit_block_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid_s[w] = valid_r[w][index_s];
            way_hit_s[w]   = valid_r[w][index_s] && (tag_r[w][index_s] == tag_s);
            // Tags within a set are unique, so at most one way contributes.
            hit_block_s    = hit_block_s | (data_r[w][index_s] & {BLK_W{way_hit_s[w]}});
        end
        hit_s     = I_READ & (|way_hit_s);
        hit_way_s = way_hit_s[1];
    end

    // Word-within-block select and read data gating.
    always_comb begin
        word_data_s = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            word_data_s = word_data_s |
                (hit_block_s[k*WORD_W +: WORD_W] & {WORD_W{word_s == WORD_OFF_W'(k)}});
        end
        if (hit_s) begin
            I_READDATA = word_data_s;
        end else begin
            I_READDATA = '0;
        end
    end

    // Victim choice: lowest invalid way, otherwise the set's LRU way.
    always_comb begin
        victim_s = 1'b0;
        if (WAYS > 1) begin
            if (!set_valid_s[0]) begin
                victim_s = 1'b0;
            end else if (!set_valid_s[1]) begin
                victim_s = 1'b1;
            end else begin
                victim_s = lru_r[index_s];
            end
        end else begin
            victim_s = 1'b0;
        end
    end

    // Next-state logic; a requested or pending flush outranks a miss.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (I_FLUSH || flush_pend_r) begin
                    state_s = ST_FLUSH;
                end else if (I_READ && !hit_s) begin
                    state_s = ST_MEM_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM_READ: begin
                if (!i_mem_busywait) begin
                    state_s = ST_UPDATE;
                end else begin
                    state_s = ST_MEM_READ;
                end
            end
            ST_UPDATE: state_s = ST_IDLE;
            ST_FLUSH:  state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State-decoded outputs; held at zero while reset is asserted.
    always_comb begin
        I_BUSYWAIT    = 1'b0;
        i_mem_read    = 1'b0;
        i_mem_address = '0;
        if (!RESET_N) begin
            I_BUSYWAIT = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: I_BUSYWAIT = I_READ & ~hit_s;
                ST_MEM_READ: begin
                    I_BUSYWAIT    = 1'b1;
                    i_mem_read    = 1'b1;
                    i_mem_address = miss_addr_r;
                end
                ST_UPDATE: I_BUSYWAIT = 1'b1;
                ST_FLUSH:  I_BUSYWAIT = 1'b1;
                default:   I_BUSYWAIT = 1'b0;
            endcase
        end
    end

    // Control state: FSM, valid bits, LRU, latched miss and pending flush.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            lru_r        <= '0;
            flush_pend_r <= 1'b0;
            miss_addr_r  <= '0;
            victim_r     <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid_r[w] <= '0;
            end
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (hit_s) begin
                        lru_r[index_s] <= ~hit_way_s;
                    end
                    if (state_s == ST_MEM_READ) begin
                        miss_addr_r <= {tag_s, index_s};
                        victim_r    <= victim_s;
                    end
                end
                ST_MEM_READ: begin
                    if (I_FLUSH) begin
                        flush_pend_r <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (I_FLUSH) begin
                        flush_pend_r <= 1'b1;
                    end
                    for (int w = 0; w < WAYS; w++) begin
                        if (victim_r == 1'(w)) begin
                            valid_r[w][fill_index_s] <= 1'b1;
                        end
                    end
                    lru_r[fill_index_s] <= ~victim_r;
                end
                ST_FLUSH: begin
                    flush_pend_r <= 1'b0;
                    for (int w = 0; w < WAYS; w++) begin
                        valid_r[w] <= '0;
                    end
                end
                default: begin
                    flush_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Block capture on memory completion and line write during UPDATE.
    always_ff @(posedge CLK) begin
        if (state_r == ST_MEM_READ && !i_mem_busywait) begin
            fill_data_r <= i_mem_readdata;
        end
        if (state_r == ST_UPDATE) begin
            for (int w = 0; w < WAYS; w++) begin
                if (victim_r == 1'(w)) begin
                    data_r[w][fill_index_s] <= fill_data_r;
                    tag_r[w][fill_index_s]  <= fill_tag_s;
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Saturating hit/miss statistics; a flush leaves them untouched.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (state_r == ST_IDLE && hit_s && hit_count_r != 32'hFFFF_FFFF) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (state_r == ST_IDLE && state_s == ST_MEM_READ && miss_count_r != 32'hFFFF_FFFF) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// ---------------------------------------------------------------------------
// tb_icache_sa
//   Self-checking bench for icache_sa (default parameters). A recency-list
//   reference model predicts hit/miss and stall length for every fetch; the
//   expectations are queued and a negedge monitor compares them against the
//   data and stall cycles the DUT presents. Block fetches seen on the memory
//   port are compared against a second queue of predicted fills.
// ---------------------------------------------------------------------------
module tb_icache_sa;

    localparam int MEM_CYC    = 5;            // MEM_READ cycles per fill with this memory
    localparam int MISS_STALL = MEM_CYC + 2;  // IDLE miss cycle + MEM_READ cycles + UPDATE

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         I_READ;
    logic [9:0]   I_ADDRESS;
    logic         I_FLUSH;
    logic [31:0]  I_READDATA;
    logic         I_BUSYWAIT;
    logic         i_mem_read;
    logic [5:0]   i_mem_address;
    logic [127:0] i_mem_readdata;
    logic         i_mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    icache_sa dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .I_READ         (I_READ),
        .I_ADDRESS      (I_ADDRESS),
        .I_FLUSH        (I_FLUSH),
        .I_READDATA     (I_READDATA),
        .I_BUSYWAIT     (I_BUSYWAIT),
        .i_mem_read     (i_mem_read),
        .i_mem_address  (i_mem_address),
        .i_mem_readdata (i_mem_readdata),
        .i_mem_busywait (i_mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] word_val(input logic [7:0] wa);
        return {wa, 8'h5A, ~wa, wa ^ 8'hC3};
    endfunction

    int mem_cnt = 0;
    always @(posedge CLK) begin
        if (i_mem_read) mem_cnt <= mem_cnt + 1;
        else            mem_cnt <= 0;
    end

    always_comb begin
        i_mem_busywait = i_mem_read && (mem_cnt < MEM_CYC - 1);
        for (int k = 0; k < 4; k++)
            i_mem_readdata[k*32 +: 32] = word_val({i_mem_address, 2'(k)});
    end

    // ---------------- checking bookkeeping ----------------
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [7:0]  stall;
    } exp_t;

    exp_t       exp_q [$];
    logic [5:0] fill_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model: per-set recency list ----------------
    logic [2:0] m_tag [8][2];   // position 0 = most recently used
    int         m_cnt [8];

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    endtask

    task automatic model_access(input logic [9:0] a, output bit hit);
        int idx;
        int pos;
        logic [2:0] tg;
        idx = int'(a[6:4]);
        tg  = a[9:7];
        pos = -1;
        for (int i = 0; i < m_cnt[idx]; i++)
            if (m_tag[idx][i] == tg) pos = i;
        hit = (pos >= 0);
        if (!hit) begin
            fill_q.push_back(a[9:4]);
            exp_misses++;
            if (m_cnt[idx] < 2) begin
                pos = m_cnt[idx];
                m_cnt[idx]++;
            end else begin
                pos = 1;   // least recently used entry is dropped
            end
        end
        for (int i = pos; i > 0; i--) m_tag[idx][i] = m_tag[idx][i-1];
        m_tag[idx][0] = tg;
    endtask

    // ---------------- monitor ----------------
    int   stall_cnt = 0;
    logic mem_read_prev = 1'b0;
    exp_t mon_e;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            stall_cnt     <= 0;
            mem_read_prev <= 1'b0;
        end else begin
            if (i_mem_read && !mem_read_prev) begin
                if (fill_q.size() == 0) check("unexpected_fill", {26'd0, i_mem_address}, 32'hFFFF_FFFF);
                else check("fill_addr", {26'd0, i_mem_address}, {26'd0, fill_q.pop_front()});
            end
            mem_read_prev <= i_mem_read;
            if (!I_READ) begin
                check("idle_rdata", I_READDATA, 32'd0);
            end else if (I_BUSYWAIT) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rdata", I_READDATA, mon_e.data);
                    check("stall_cycles", stall_cnt, {24'd0, mon_e.stall});
                end
                stall_cnt <= 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done();
        int n;
        n = 0;
        @(negedge CLK);
        while (I_BUSYWAIT && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (I_BUSYWAIT) check("read_timeout", 32'd1, 32'd0);
        @(posedge CLK); #1;
        I_READ = 1'b0;
    endtask

    task automatic issue_read(input logic [9:0] a);
        bit   h;
        exp_t e;
        model_access(a, h);
        e.addr  = a;
        e.data  = word_val(a[9:2]);
        e.stall = h ? 8'd0 : 8'(MISS_STALL);
        exp_q.push_back(e);
        exp_hits++;
        I_READ    = 1'b1;
        I_ADDRESS = a;
        wait_done();
    endtask

    task automatic flush_idle();
        I_READ  = 1'b0;
        I_FLUSH = 1'b1;
        @(negedge CLK);
        check("flush_pulse_busy", {31'd0, I_BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        I_FLUSH = 1'b0;
        @(negedge CLK);
        check("flush_state_busy", {31'd0, I_BUSYWAIT}, 32'd1);
        @(posedge CLK); #1;
        model_clear();
    endtask

    // Flush pulse while the fill is in MEM_READ: the fill completes and the
    // fetch is served, then the deferred flush wipes the cache.
    task automatic read_with_flush(input logic [9:0] a);
        bit   h;
        exp_t e;
        flush_idle();
        model_access(a, h);
        e.addr  = a;
        e.data  = word_val(a[9:2]);
        e.stall = 8'(MISS_STALL);
        exp_q.push_back(e);
        exp_hits++;
        I_READ    = 1'b1;
        I_ADDRESS = a;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        I_FLUSH = 1'b1;
        @(posedge CLK); #1;
        I_FLUSH = 1'b0;
        wait_done();
        @(negedge CLK);
        check("deferred_flush_busy", {31'd0, I_BUSYWAIT}, 32'd1);
        @(posedge CLK); #1;
        model_clear();
    endtask

    // Address changes mid-miss: first line is filled, then b is looked up.
    task automatic read_switch(input logic [9:0] a, input logic [9:0] b);
        bit   ha;
        bit   hb;
        exp_t e;
        flush_idle();
        model_access(a, ha);
        model_access(b, hb);
        e.addr  = b;
        e.data  = word_val(b[9:2]);
        e.stall = hb ? 8'(MISS_STALL) : 8'(2 * MISS_STALL);
        exp_q.push_back(e);
        exp_hits++;
        I_READ    = 1'b1;
        I_ADDRESS = a;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        I_ADDRESS = b;
        wait_done();
    endtask

    task automatic reset_mid_miss(input logic [9:0] a, input logic [9:0] b);
        bit h;
        int n;
        flush_idle();
        issue_read(a);
        model_access(b, h);
        I_READ    = 1'b1;
        I_ADDRESS = b;
        n = 0;
        @(negedge CLK);
        while (!i_mem_read && n < 20) begin
            n++;
            @(negedge CLK);
        end
        check("rst_fill_started", {31'd0, i_mem_read}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst_mem_read", {31'd0, i_mem_read}, 32'd0);
        check("rst_busywait", {31'd0, I_BUSYWAIT}, 32'd0);
        check("rst_rdata", I_READDATA, 32'd0);
        check("rst_mem_addr", {26'd0, i_mem_address}, 32'd0);
        I_READ = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_clear();
        fill_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge CLK); #1;
        issue_read(a);   // previously cached line must miss again
    endtask

    function automatic logic [9:0] rand_addr();
        logic [9:0] r;
        r      = 10'($urandom_range(0, 1023));
        r[9:7] = 3'($urandom_range(0, 3));
        return r;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int r;
        RESET_N   = 1'b0;
        I_READ    = 1'b1;
        I_FLUSH   = 1'b0;
        I_ADDRESS = 10'h000;
        model_clear();
        repeat (2) @(posedge CLK); #1;
        check("reset_busywait", {31'd0, I_BUSYWAIT}, 32'd0);
        check("reset_mem_read", {31'd0, i_mem_read}, 32'd0);
        check("reset_mem_addr", {26'd0, i_mem_address}, 32'd0);
        check("reset_rdata", I_READDATA, 32'd0);
        I_READ = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // cold miss, then hits across the block
        issue_read(10'h000);
        issue_read(10'h000);
        issue_read(10'h004);
        issue_read(10'h008);
        issue_read(10'h00C);

        // LRU within set 0
        flush_idle();
        issue_read(10'h000);
        issue_read(10'h080);
        issue_read(10'h000);
        issue_read(10'h100);
        issue_read(10'h000);
        issue_read(10'h080);

        // deferred flush, then the same address misses again
        read_with_flush(10'h040);
        issue_read(10'h040);
        issue_read(10'h044);

        // address change during a miss
        read_switch(10'h200, 10'h204);
        read_switch(10'h200, 10'h2A8);

        // asynchronous reset in the middle of a fill
        reset_mid_miss(10'h010, 10'h090);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)      flush_idle();
            else if (r < 5) read_with_flush(rand_addr());
            else if (r < 7) read_switch(rand_addr(), rand_addr());
            else            issue_read(rand_addr());
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
        end

        repeat (3) @(posedge CLK);
        #1;
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("fill_q_drained", fill_q.size(), 32'd0);
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
